ball_ctl: RTL and testbench
===========================

# ball_ctl

Game-logic engine that produces the ball position and scores consumed by the screen renderer. Once per video frame it advances the ball, bounces it off the top/bottom walls and the paddles, and detects misses. Sits between the paddle-position sources and `game_screen`; its `ball_xpos`/`ball_ypos` feed that block directly, and it shares the renderer's geometry.

## Interface
- `STEP`, 2: ball displacement per frame on each axis, in pixels (1..8).
- `SERVE_FRAMES`, 60: frames the ball rests at centre before each serve.
- `WIN_SCORE`, 9: score that ends the game (1..15).
- `pclk` input 1: pixel clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `vsync_in` input 1: vertical sync from the timing chain; its rising edge is the frame tick.
- `start` input 1: level; leaves IDLE or GAME_OVER.
- `left_palette_pos` input 11: centre row of the left paddle.
- `right_palette_pos` input 11: centre row of the right paddle.
- `ball_xpos` output 11: ball centre column.
- `ball_ypos` output 11: ball centre row.
- `score_left` output 4: left player score.
- `score_right` output 4: right player score.
- `point_left` output 1: one-cycle pulse when the left player scores.
- `point_right` output 1: one-cycle pulse when the right player scores.
- `game_over` output 1: high in GAME_OVER.

## Operation
- Geometry constants (must match the renderer):
  - Screen 1024x768.
  - `PALETTE_LENGTH` 100 (half-length).
  - `PALETTE_WIDTH` 10.
  - `BALL_SIZE` 3.
  - Derived limits: `X_MIN`=13, `X_MAX`=1011, `Y_MIN`=3, `Y_MAX`=764, centre (512,384).
- Frame tick: `vsync_q` is a register of `vsync_in`; tick = `vsync_in & ~vsync_q`. All motion and counters advance only on a tick.
- Direction state: `dx` (1 = right) and `dy` (1 = down).
- States:
  - IDLE: ball held at centre. `start`=1 → SERVE with `dx`=1, `dy`=1.
  - SERVE: ball held at centre; frame counter counts ticks. After `SERVE_FRAMES` ticks → PLAY.
  - PLAY: on each tick, each axis is updated independently:
    - Y: `ny = ypos ± STEP`. If `ny` crosses `Y_MIN`/`Y_MAX`, clamp to that limit and invert `dy`.
    - X moving left, `xpos <= X_MIN + STEP`: hit if `ypos + 103 > left_palette_pos` and `ypos < left_palette_pos + 103`. All compares use 12-bit unsigned arithmetic; nothing may underflow. On a hit, `xpos` = `X_MIN` and `dx` = 1. On a miss → POINT (right player scores).
    - X moving right, `xpos + STEP >= X_MAX`: same test against `right_palette_pos`. On a hit, `xpos` = `X_MAX` and `dx` = 0. On a miss → POINT (left player scores).
    - Otherwise `xpos ± STEP`.
  - POINT (one cycle, no tick needed):
    - Pulse `point_*`, increment that score, recentre the ball.
    - Serve direction: `dx` toward the player who conceded; `dy` unchanged.
    - New score = `WIN_SCORE` → GAME_OVER; else → SERVE with the frame counter cleared.
  - GAME_OVER: ball at centre, scores held. `start`=1 → clear scores → SERVE.
- `start` is ignored in SERVE, PLAY and POINT.
- A wall bounce and a paddle hit or miss in the same tick are both applied. On a miss, the Y update of that tick is discarded because the ball recentres.

## Timing
- Reset values: `ball_xpos`=512, `ball_ypos`=384, scores 0, pulses 0, `game_over`=0, state IDLE, `dx`=1, `dy`=1, `vsync_q`=0, counter 0.
- All outputs are registered.
- The position update takes effect on the same `pclk` edge at which `vsync_in` is first sampled high, so new outputs are visible one cycle after the edge is detected.
- POINT follows the missing tick by exactly one cycle. `point_*` and the score increment appear together, for one cycle.
- A `vsync_in` held high produces exactly one tick. A tick arriving while in POINT is lost (POINT lasts one cycle, so this is benign).
- Reset mid-game returns to IDLE within the assertion; there is no partial update.

## Structure
- Shared package/header `pong_defs`: screen size, `PALETTE_LENGTH`, `PALETTE_WIDTH`, `BALL_SIZE`, derived limits and centre. Used by both `ball_ctl` and the renderer.
- State encoding stays local to this block.
- One sub-module, `frame_tick`: the vsync rising-edge detector, reusable by the paddle controllers.

## Test plan
- Reset, then `start`, then 60 ticks → ball stays at (512,384) through SERVE; the next tick gives (514,386).
- Ball at y=5, moving up, `STEP`=2 → `ball_ypos`=3 and `dy` flips; the next tick gives 5.
- Moving left from x=15, `ball_ypos`=300, `left_palette_pos`=250 → `xpos`=13, `dx`=1, no point.
- Same as the previous case but `left_palette_pos`=500 → `point_right` pulses for one cycle, `score_right`=1, ball at centre, `dx`=0 at serve.
- `score_left`=8 and a right-paddle miss → `score_left`=9, `game_over`=1. `start` then clears both scores and enters SERVE.
- `left_palette_pos`=20 with the ball at y=3 → hit detected, with no underflow false-miss. Assert `rst` mid-PLAY → all outputs return to their reset values.

Source files
------------

// File: rtl/pong_defs.sv
// Shared playfield geometry for the pong game logic and the screen renderer.
// The limits are derived here so that both sides always agree on where the
// ball is allowed to travel.
package pong_defs;

  localparam int SCREEN_W       = 1024;
  localparam int SCREEN_H       = 768;
  localparam int PALETTE_LENGTH = 100;  // half-length of a paddle
  localparam int PALETTE_WIDTH  = 10;
  localparam int BALL_SIZE      = 3;

  localparam int X_MIN    = PALETTE_WIDTH + BALL_SIZE;             // 13
  localparam int X_MAX    = SCREEN_W - PALETTE_WIDTH - BALL_SIZE;  // 1011
  localparam int Y_MIN    = BALL_SIZE;                             // 3
  localparam int Y_MAX    = SCREEN_H - 1 - BALL_SIZE;              // 764
  localparam int X_CENTRE = SCREEN_W / 2;                          // 512
  localparam int Y_CENTRE = SCREEN_H / 2;                          // 384

  // Vertical distance from paddle centre at which the ball still touches it.
  localparam logic [11:0] HIT_REACH_W = 12'(PALETTE_LENGTH + BALL_SIZE);

  typedef logic [10:0] coord_t;

  // Ball overlaps the paddle vertically. Widened to 12 bits and written with
  // additions only, so a paddle near row 0 can never wrap into a false miss.
  function automatic logic paddle_hit(input coord_t ball_y, input coord_t pad_y);
    logic [11:0] by;
    logic [11:0] py;
    by = {1'b0, ball_y};
    py = {1'b0, pad_y};
    return ((by + HIT_REACH_W) > py) && (by < (py + HIT_REACH_W));
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector on vertical sync. The tick is combinational so that the
// consumer acts on the very edge at which vsync is first sampled high.
module frame_tick (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_q_r;

  // Remember the previous vsync sample.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q_r <= 1'b0;
    end else begin
      vsync_q_r <= vsync_in;
    end
  end

  assign tick = vsync_in & ~vsync_q_r;

endmodule

// File: rtl/ball_ctl.sv
// Pong game engine: once per frame moves the ball, bounces it off the walls
// and paddles, detects misses, keeps score and ends the game at WIN_SCORE.
module ball_ctl
  import pong_defs::*;
#(
  parameter int unsigned STEP         = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        start,
  input  logic [10:0] left_palette_pos,
  input  logic [10:0] right_palette_pos,
  output logic [10:0] ball_xpos,
  output logic [10:0] ball_ypos,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        point_left,
  output logic        point_right,
  output logic        game_over
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [11:0] STEP_W  = 12'(STEP);
  localparam logic [11:0] X_MIN_W = 12'(X_MIN);
  localparam logic [11:0] X_MAX_W = 12'(X_MAX);
  localparam logic [11:0] Y_MIN_W = 12'(Y_MIN);
  localparam logic [11:0] Y_MAX_W = 12'(Y_MAX);
  localparam logic [10:0] X_MIN_C = 11'(X_MIN);
  localparam logic [10:0] X_MAX_C = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_C = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_C = 11'(Y_MAX);
  localparam logic [10:0] X_CTR_C = 11'(X_CENTRE);
  localparam logic [10:0] Y_CTR_C = 11'(Y_CENTRE);
  localparam logic [3:0]  WIN_C   = 4'(WIN_SCORE);

  state_t           state_r;
  logic             dx_r;           // 1 = moving right
  logic             dy_r;           // 1 = moving down
  logic             left_scored_r;  // which side earned the pending point
  logic [CNT_W-1:0] cnt_r;

  logic             tick_s;
  logic [11:0]      x_wide_s;
  logic [11:0]      y_wide_s;
  logic [10:0]      nx_s;
  logic [10:0]      ny_s;
  logic             ndx_s;
  logic             ndy_s;
  logic             miss_s;

  frame_tick u_frame_tick (
    .pclk     (pclk),
    .rst      (rst),
    .vsync_in (vsync_in),
    .tick     (tick_s)
  );

  assign x_wide_s = {1'b0, ball_xpos};
  assign y_wide_s = {1'b0, ball_ypos};

  // Candidate vertical move: step, or clamp to the wall and reverse.
  always_comb begin
    ny_s  = ball_ypos;
    ndy_s = dy_r;
    if (dy_r) begin
      if ((y_wide_s + STEP_W) >= Y_MAX_W) begin
        ny_s  = Y_MAX_C;
        ndy_s = 1'b0;
      end else begin
        ny_s  = 11'(y_wide_s + STEP_W);
        ndy_s = 1'b1;
      end
    end else begin
      if (y_wide_s <= (Y_MIN_W + STEP_W)) begin
        ny_s  = Y_MIN_C;
        ndy_s = 1'b1;
      end else begin
        ny_s  = 11'(y_wide_s - STEP_W);
        ndy_s = 1'b0;
      end
    end
  end

  // Candidate horizontal move: step, paddle return, or miss at either edge.
  always_comb begin
    nx_s   = ball_xpos;
    ndx_s  = dx_r;
    miss_s = 1'b0;
    if (dx_r) begin
      if ((x_wide_s + STEP_W) >= X_MAX_W) begin
        if (paddle_hit(ball_ypos, right_palette_pos)) begin
          nx_s  = X_MAX_C;
          ndx_s = 1'b0;
        end else begin
          miss_s = 1'b1;
        end
      end else begin
        nx_s = 11'(x_wide_s + STEP_W);
      end
    end else begin
      if (x_wide_s <= (X_MIN_W + STEP_W)) begin
        if (paddle_hit(ball_ypos, left_palette_pos)) begin
          nx_s  = X_MIN_C;
          ndx_s = 1'b1;
        end else begin
          miss_s = 1'b1;
        end
      end else begin
        nx_s = 11'(x_wide_s - STEP_W);
      end
    end
  end

  // Game state machine with all outputs registered.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      dx_r          <= 1'b1;
      dy_r          <= 1'b1;
      left_scored_r <= 1'b0;
      cnt_r         <= '0;
      ball_xpos     <= X_CTR_C;
      ball_ypos     <= Y_CTR_C;
      score_left    <= 4'd0;
      score_right   <= 4'd0;
      point_left    <= 1'b0;
      point_right   <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      point_left  <= 1'b0;
      point_right <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ball_xpos <= X_CTR_C;
          ball_ypos <= Y_CTR_C;
          if (start) begin
            state_r <= ST_SERVE;
            dx_r    <= 1'b1;
            dy_r    <= 1'b1;
            cnt_r   <= '0;
          end
        end
        ST_SERVE: begin
          ball_xpos <= X_CTR_C;
          ball_ypos <= Y_CTR_C;
          if (tick_s) begin
            if (cnt_r == SERVE_LAST) begin
              state_r <= ST_PLAY;
              cnt_r   <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        ST_PLAY: begin
          if (tick_s) begin
            if (miss_s) begin
              // Ball recentres in POINT, so this tick's Y move is dropped.
              state_r       <= ST_POINT;
              left_scored_r <= dx_r;
            end else begin
              ball_xpos <= nx_s;
              ball_ypos <= ny_s;
              dx_r      <= ndx_s;
              dy_r      <= ndy_s;
            end
          end
        end
        ST_POINT: begin
          ball_xpos <= X_CTR_C;
          ball_ypos <= Y_CTR_C;
          cnt_r     <= '0;
          if (left_scored_r) begin
            // Right conceded: serve toward the right.
            score_left <= score_left + 4'd1;
            point_left <= 1'b1;
            dx_r       <= 1'b1;
            if ((score_left + 4'd1) == WIN_C) begin
              state_r   <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state_r <= ST_SERVE;
            end
          end else begin
            score_right <= score_right + 4'd1;
            point_right <= 1'b1;
            dx_r        <= 1'b0;
            if ((score_right + 4'd1) == WIN_C) begin
              state_r   <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state_r <= ST_SERVE;
            end
          end
        end
        ST_GAME_OVER: begin
          ball_xpos <= X_CTR_C;
          ball_ypos <= Y_CTR_C;
          if (start) begin
            state_r     <= ST_SERVE;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            game_over   <= 1'b0;
            cnt_r       <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: walks full rallies with STEP=2 and checks
// hand-computed ball positions, bounces, paddle hits, misses, scoring,
// game over, restart and asynchronous reset.
module tb_ball_ctl;

  logic        pclk;
  logic        rst;
  logic        vsync_in;
  logic        start;
  logic [10:0] left_palette_pos;
  logic [10:0] right_palette_pos;
  logic [10:0] ball_xpos;
  logic [10:0] ball_ypos;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        point_left;
  logic        point_right;
  logic        game_over;

  int n_cmp;
  int n_bad;

  ball_ctl #(
    .STEP         (2),
    .SERVE_FRAMES (60),
    .WIN_SCORE    (9)
  ) dut (
    .pclk              (pclk),
    .rst               (rst),
    .vsync_in          (vsync_in),
    .start             (start),
    .left_palette_pos  (left_palette_pos),
    .right_palette_pos (right_palette_pos),
    .ball_xpos         (ball_xpos),
    .ball_ypos         (ball_ypos),
    .score_left        (score_left),
    .score_right       (score_right),
    .point_left        (point_left),
    .point_right       (point_right),
    .game_over         (game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, ".x"}, 32'(ball_xpos), 32'(x));
    check({tag, ".y"}, 32'(ball_ypos), 32'(y));
  endtask

  task automatic vs_rise();
    vsync_in = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic vs_fall();
    vsync_in = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  task automatic tick();
    vs_rise();
    vs_fall();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge pclk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    n_cmp             = 0;
    n_bad             = 0;
    rst               = 1'b1;
    vsync_in          = 1'b0;
    start             = 1'b0;
    left_palette_pos  = 11'd1023;
    right_palette_pos = 11'd700;

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check_ball("reset", 512, 384);
    check("reset.score_l", 32'(score_left), 32'd0);
    check("reset.score_r", 32'(score_right), 32'd0);
    check("reset.pulses", 32'({point_left, point_right}), 32'd0);
    check("reset.game_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    @(posedge pclk);
    #1;

    // IDLE ignores ticks
    tick();
    check_ball("idle_tick", 512, 384);

    // Serve: 60 ticks at centre, then motion right/down
    pulse_start();
    ticks(60);
    check_ball("serve_60", 512, 384);
    tick();
    check_ball("play_1", 514, 386);

    // A long vsync pulse is still one tick
    vsync_in = 1'b1;
    repeat (5) @(posedge pclk);
    #1;
    vs_fall();
    check_ball("long_vsync", 516, 388);

    // Bottom wall bounce
    ticks(188);
    check_ball("play_190", 892, 764);
    tick();
    check_ball("play_191", 894, 762);

    // Right paddle hit (y=646, paddle 700)
    ticks(58);
    check_ball("play_249", 1010, 646);
    tick();
    check_ball("right_hit", 1011, 644);
    check("right_hit.point_l", 32'(point_left), 32'd0);
    check("right_hit.score_l", 32'(score_left), 32'd0);

    // Top wall bounce from y=4 moving up
    ticks(320);
    check_ball("top_pre", 371, 4);
    tick();
    check_ball("top_clamp", 369, 3);
    tick();
    check_ball("top_after", 367, 5);

    // Left miss from x=15, y=357, paddle 500
    ticks(176);
    check_ball("left_edge", 15, 357);
    left_palette_pos = 11'd500;
    vs_rise();
    check("miss.no_pulse_yet", 32'(point_right), 32'd0);
    check("miss.score_not_yet", 32'(score_right), 32'd0);
    vs_fall();
    check("miss.point_r", 32'(point_right), 32'd1);
    check("miss.score_r", 32'(score_right), 32'd1);
    check("miss.score_l", 32'(score_left), 32'd0);
    check_ball("miss.centre", 512, 384);
    @(posedge pclk);
    #1;
    check("miss.pulse_end", 32'(point_right), 32'd0);
    check("miss.score_hold", 32'(score_right), 32'd1);

    // Serve toward the right player's opponent: dx=0, dy=1
    left_palette_pos  = 11'd700;
    right_palette_pos = 11'd1023;
    ticks(60);
    check_ball("serve2_60", 512, 384);
    tick();
    check_ball("serve2_dir", 510, 386);
    ticks(248);
    check_ball("serve2_249", 14, 646);
    tick();
    check_ball("left_hit", 13, 644);
    check("left_hit.point_r", 32'(point_right), 32'd0);
    check("left_hit.score_r", 32'(score_right), 32'd1);

    // Right miss -> left scores
    ticks(498);
    check_ball("right_edge", 1009, 357);
    tick();
    check("rmiss.point_l", 32'(point_left), 32'd1);
    check("rmiss.score_l", 32'(score_left), 32'd1);
    check_ball("rmiss.centre", 512, 384);

    // Left wins the game with eight more right misses
    for (int p = 2; p <= 9; p++) begin
      ticks(310);
      if (p == 8) begin
        check("score_l_8", 32'(score_left), 32'd8);
        check("not_over_at_8", 32'(game_over), 32'd0);
      end
    end
    check("win.score_l", 32'(score_left), 32'd9);
    check("win.score_r", 32'(score_right), 32'd1);
    check("win.game_over", 32'(game_over), 32'd1);
    check("win.point_l", 32'(point_left), 32'd1);
    tick();
    check("over.hold_score", 32'(score_left), 32'd9);
    check_ball("over.centre", 512, 384);

    // Restart clears scores
    pulse_start();
    check("restart.score_l", 32'(score_left), 32'd0);
    check("restart.score_r", 32'(score_right), 32'd0);
    check("restart.game_over", 32'(game_over), 32'd0);
    ticks(60);
    check_ball("restart_serve", 512, 384);
    tick();
    check_ball("restart_1", 514, 386);
    ticks(249);
    check("restart.rmiss", 32'(score_left), 32'd1);

    // Rally moving up: reaches y=3, then right paddle at row 20 hits at y=119
    ticks(60);
    tick();
    check_ball("up_1", 514, 382);
    ticks(189);
    check_ball("up_190", 892, 4);
    tick();
    check_ball("up_191", 894, 3);
    ticks(58);
    check_ball("up_249", 1010, 119);
    right_palette_pos = 11'd20;
    tick();
    check_ball("low_pad_hit", 1011, 121);
    check("low_pad.point_l", 32'(point_left), 32'd0);
    check("low_pad.score_l", 32'(score_left), 32'd1);
    tick();
    check_ball("low_pad_after", 1009, 123);

    // Asynchronous reset in the middle of play
    #2;
    rst = 1'b1;
    #1;
    check_ball("midrst", 512, 384);
    check("midrst.score_l", 32'(score_left), 32'd0);
    check("midrst.score_r", 32'(score_right), 32'd0);
    check("midrst.game_over", 32'(game_over), 32'd0);
    @(posedge pclk);
    #1;
    rst = 1'b0;
    tick();
    check_ball("midrst.idle", 512, 384);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
